msg_checker: RTL and testbench

- Downstream consumer of the RC4 decrypt stage.
- After the decryptor has written a MSG_LEN-byte plaintext into the decrypted-message RAM, this block reads it back byte by byte.
- It checks every byte against the legal plaintext alphabet: lowercase 'a'–'z' (0x61–0x7A) or space (0x20).
- It reports pass/fail, the first offending index and LED status. The key-search controller uses the verdict to accept the current secret_key or advance to the next one.

---
 rtl/rc4_pkg.sv | 20 ++
 rtl/msg_checker.sv | 96 +++++++++
 tb/tb_msg_checker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state encoding, plaintext alphabet constants and legality helper
package rc4_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;
    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_CHECK  = ST_CHECK,
        S_REPORT = ST_REPORT
    } state_t;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_Z     = 8'h7A;
    localparam int MSG_LEN_DEFAULT    = 32;
    function automatic logic is_legal_char(input logic [7:0] c);
        return (c >= CHAR_A && c <= CHAR_Z) || c == CHAR_SPACE;
    endfunction
endpackage

// File: rtl/msg_checker.sv
// msg_checker: reads back a decrypted message and verifies every byte is lowercase or space
module msg_checker
    import rc4_pkg::*;
#(
    parameter int MSG_LEN   = MSG_LEN_DEFAULT,
    parameter int ADDR_W    = 8,
    parameter int READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        q_d,
    output logic [ADDR_W-1:0] address_d,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_index,
    output logic [1:0]        LED
);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(MSG_LEN - 1);
    localparam logic [1:0] WAIT_LAST = 2'(READ_WAIT - 1);
    state_t state, state_n;
    logic [ADDR_W:0] idx, idx_n;
    logic [1:0] cnt, cnt_n;
    logic [ADDR_W-1:0] address_n, fail_index_n;
    logic done_n, pass_n;
    logic [1:0] led, led_n;
    assign busy = state != S_IDLE;
    assign LED = led;
    // next-state and next-register values; idx carries one extra bit so MSG_LEN=256 cannot wrap
    always_comb begin
        state_n = state;
        idx_n = idx;
        cnt_n = cnt;
        address_n = address_d;
        fail_index_n = fail_index;
        pass_n = pass;
        led_n = led;
        done_n = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                idx_n = '0;
                address_n = '0;
                led_n = 2'b00;
                pass_n = 1'b0;
                cnt_n = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                cnt_n = cnt + 2'd1;
                state_n = cnt == WAIT_LAST ? S_CHECK : S_WAIT;
            end
            S_CHECK: if (!is_legal_char(q_d)) begin
                fail_index_n = idx[ADDR_W-1:0];
                pass_n = 1'b0;
                state_n = S_REPORT;
            end else if (idx == LAST) begin
                pass_n = 1'b1;
                state_n = S_REPORT;
            end else begin
                idx_n = idx + 1'b1;
                address_n = ADDR_W'(idx + 1'b1);
                cnt_n = '0;
                state_n = S_WAIT;
            end
            S_REPORT: begin
                done_n = 1'b1;
                led_n = pass ? 2'b10 : 2'b01;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
    // register all state; reset abandons any check in flight without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx <= '0;
            cnt <= '0;
            address_d <= '0;
            fail_index <= '0;
            pass <= 1'b0;
            led <= 2'b00;
            done <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            cnt <= cnt_n;
            address_d <= address_n;
            fail_index <= fail_index_n;
            pass <= pass_n;
            led <= led_n;
            done <= done_n;
        end
    end
endmodule

// File: tb/tb_msg_checker.sv
// tb_msg_checker: scoreboard bench over three checker configurations with behavioural RAMs
module tb_msg_checker;
    localparam int N[3]  = '{32, 1, 256};
    localparam int RW[3] = '{1, 1, 3};
    typedef struct {
        int d;
        logic ok;
        int fi;
        int last;
        int cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    logic start[3];
    logic [7:0] q[3], addr[3], fi[3];
    logic busy[3], done[3], pass[3];
    logic [1:0] led[3];
    logic [7:0] mem[3][256];
    logic [7:0] p[3][3];
    bit legal[256];
    string alpha = "abcdefghijklmnopqrstuvwxyz ";
    string msg = "attack at dawn attack at dusk ok";
    exp_t sbq[$];
    exp_t me, e1, e2;
    int amax[3];
    int checks = 0, passes = 0;
    always #5 clk = ~clk;
    // edge counter: at a negedge it holds the number of the preceding rising edge
    always @(posedge clk) cyc <= cyc + 1;
    msg_checker #(.MSG_LEN(32), .ADDR_W(8), .READ_WAIT(1)) u0 (
        .clk(clk), .reset(rst), .start(start[0]), .q_d(q[0]), .address_d(addr[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .fail_index(fi[0]), .LED(led[0]));
    msg_checker #(.MSG_LEN(1), .ADDR_W(8), .READ_WAIT(1)) u1 (
        .clk(clk), .reset(rst), .start(start[1]), .q_d(q[1]), .address_d(addr[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .fail_index(fi[1]), .LED(led[1]));
    msg_checker #(.MSG_LEN(256), .ADDR_W(8), .READ_WAIT(3)) u2 (
        .clk(clk), .reset(rst), .start(start[2]), .q_d(q[2]), .address_d(addr[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .fail_index(fi[2]), .LED(led[2]));
    // RAM models: read data delayed by READ_WAIT registers after the address
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            p[d][0] <= mem[d][addr[d]];
            p[d][1] <= p[d][0];
            p[d][2] <= p[d][1];
        end
    end
    assign q[0] = p[0][0];
    assign q[1] = p[1][0];
    assign q[2] = p[2][2];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    function automatic exp_t model(input int d, input int acc);
        exp_t e;
        e.d = d;
        e.ok = 1'b1;
        e.fi = 0;
        e.last = N[d] - 1;
        for (int i = 0; i < N[d]; i++) begin
            if (!legal[mem[d][i]]) begin
                e.ok = 1'b0;
                e.fi = i;
                e.last = i;
                break;
            end
        end
        e.cyc = acc + (RW[d] + 1) * (e.last + 1) + 1;
        return e;
    endfunction
    // monitor: every done pulse is matched against the oldest expected verdict
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done[d]) begin
                if (sbq.size() == 0 || sbq[0].d != d) chk($sformatf("dut%0d_unexpected_done", d), int'(done[d]), 0);
                else begin
                    me = sbq.pop_front();
                    chk($sformatf("dut%0d_pass", d), int'(pass[d]), int'(me.ok));
                    if (!me.ok) chk($sformatf("dut%0d_fail_index", d), int'(fi[d]), me.fi);
                    chk($sformatf("dut%0d_led", d), int'(led[d]), me.ok ? 2 : 1);
                    chk($sformatf("dut%0d_done_edge", d), cyc, me.cyc);
                    chk($sformatf("dut%0d_busy_at_done", d), int'(busy[d]), 0);
                    chk($sformatf("dut%0d_max_address", d), amax[d], me.last % 256);
                end
            end
            amax[d] = busy[d] ? (int'(addr[d]) > amax[d] ? int'(addr[d]) : amax[d]) : 0;
        end
    end
    task automatic go(input int d, output int acc);
        @(negedge clk);
        acc = cyc + 1;
        start[d] = 1'b1;
        sbq.push_back(model(d, acc));
        @(negedge clk);
        start[d] = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            chk("verdict_timeout", sbq.size(), 0);
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask
    task automatic load_msg();
        for (int i = 0; i < 32; i++) mem[0][i] = msg[i];
    endtask
    task automatic rnd_fill(input int d, input int pct_bad);
        logic [7:0] b;
        for (int i = 0; i < N[d]; i++) mem[d][i] = alpha[$urandom_range(26)];
        if ($urandom_range(99) < pct_bad) begin
            do b = 8'($urandom_range(255)); while (legal[b]);
            mem[d][$urandom_range(N[d] - 1)] = b;
        end
    endtask
    initial begin
        int acc;
        for (int i = 0; i < alpha.len(); i++) legal[alpha[i]] = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0;
            for (int i = 0; i < 256; i++) mem[d][i] = "a";
        end
        repeat (3) @(negedge clk);
        chk("reset_address", int'(addr[0]), 0);
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_done", int'(done[0]), 0);
        chk("reset_pass", int'(pass[0]), 0);
        chk("reset_fail_index", int'(fi[0]), 0);
        chk("reset_led", int'(led[0]), 0);
        rst = 1'b0;
        load_msg();
        go(0, acc);
        drain();
        chk("pass_led_after", int'(led[0]), 2);
        chk("pass_busy_after", int'(busy[0]), 0);
        mem[0][5] = 8'h41;
        go(0, acc);
        drain();
        load_msg();
        mem[0][0] = 8'h60;
        go(0, acc);
        drain();
        load_msg();
        mem[0][31] = 8'h7B;
        go(0, acc);
        drain();
        load_msg();
        mem[0][0] = 8'h61;
        mem[0][1] = 8'h7A;
        mem[0][2] = 8'h20;
        go(0, acc);
        drain();
        load_msg();
        go(0, acc);
        while (cyc < acc + 19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_address", int'(addr[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_led", int'(led[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        rst = 1'b0;
        void'(sbq.pop_back());
        repeat (100) @(negedge clk);
        go(0, acc);
        while (cyc < acc + 2) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        while (cyc < acc + 9) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        drain();
        mem[0][20] = 8'h7B;
        @(negedge clk);
        start[0] = 1'b1;
        e1 = model(0, cyc + 1);
        e2 = model(0, e1.cyc + 1);
        sbq.push_back(e1);
        sbq.push_back(e2);
        for (int n = 0; n < 200 && sbq.size() > 1; n++) @(negedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        drain();
        mem[1][0] = "q";
        go(1, acc);
        drain();
        mem[1][0] = 8'h00;
        go(1, acc);
        drain();
        chk("len1_fail_led", int'(led[1]), 1);
        rnd_fill(2, 0);
        go(2, acc);
        drain();
        chk("len256_pass_led", int'(led[2]), 2);
        repeat (3) begin
            rnd_fill(2, 70);
            go(2, acc);
            drain();
        end
        repeat (12) begin
            rnd_fill(0, 50);
            go(0, acc);
            drain();
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
